// File: rtl/mac_seq.sv
// Length-sequenced multiply-accumulate cell for a MAC row: counted runs with Done, sticky Ovf.
// Build option: define MAC_SAT_EN to clamp Cout at the mode's extreme on overflow (default wraps).
module mac_seq #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ACC_WIDTH  = 24,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  Start,
   input  logic [CNT_WIDTH-1:0]  Len,
   input  logic                  Signed,
   input  logic                  En,
   input  logic                  Clr,
   input  logic [DATA_WIDTH-1:0] Ain,
   input  logic [DATA_WIDTH-1:0] Bin,
   output logic [DATA_WIDTH-1:0] Bout,
   output logic [ACC_WIDTH-1:0]  Cout,
   output logic [CNT_WIDTH-1:0]  Cnt,
   output logic                  Done,
   output logic                  Ovf
);

   localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                 state;
   logic                   v1;
   logic                   sgn_q;
   logic [PROD_WIDTH-1:0]  prod_q;
   logic [CNT_WIDTH-1:0]   len_q;

   logic                   start_c;
   logic                   accept_c;
   logic                   mode_c;
   logic signed [PROD_WIDTH-1:0] a_s_c;
   logic signed [PROD_WIDTH-1:0] b_s_c;
   logic [PROD_WIDTH-1:0]  prod_c;
   logic [ACC_WIDTH-1:0]   ext_c;
   logic [ACC_WIDTH:0]     sum_c;
   logic                   ovf_c;
   logic [ACC_WIDTH-1:0]   acc_c;
   logic [CNT_WIDTH-1:0]   cnt_inc_c;

   // Start is honoured only where a new run may begin; En is accepted outside DRAIN and idle DONE
   always_comb begin
      start_c  = Start && (state == IDLE || state == DONE);
      accept_c = En && (state == IDLE || state == RUN || (state == DONE && Start));
      mode_c   = start_c ? Signed : sgn_q;
      cnt_inc_c = Cnt + CNT_WIDTH'(1);
   end

   // Stage-1 product in the run's operand mode
   always_comb begin
      a_s_c = PROD_WIDTH'($signed(Ain));
      b_s_c = PROD_WIDTH'($signed(Bin));
      if (mode_c) begin
         prod_c = PROD_WIDTH'(a_s_c * b_s_c);
      end else begin
         prod_c = PROD_WIDTH'(Ain) * PROD_WIDTH'(Bin);
      end
   end

   // Stage-2 add with overflow detection; sign of Cout picks the signed clamp direction
   always_comb begin
      if (sgn_q) begin
         ext_c = ACC_WIDTH'($signed(prod_q));
      end else begin
         ext_c = ACC_WIDTH'(prod_q);
      end
      sum_c = {1'b0, Cout} + {1'b0, ext_c};
      if (sgn_q) begin
         ovf_c = (Cout[ACC_WIDTH-1] == ext_c[ACC_WIDTH-1]) &&
                 (sum_c[ACC_WIDTH-1] != Cout[ACC_WIDTH-1]);
      end else begin
         ovf_c = sum_c[ACC_WIDTH];
      end
`ifdef MAC_SAT_EN
      if (Ovf) begin
         acc_c = Cout;
      end else if (ovf_c) begin
         if (!sgn_q) begin
            acc_c = '1;
         end else if (Cout[ACC_WIDTH-1]) begin
            acc_c = {1'b1, {(ACC_WIDTH-1){1'b0}}};
         end else begin
            acc_c = {1'b0, {(ACC_WIDTH-1){1'b1}}};
         end
      end else begin
         acc_c = sum_c[ACC_WIDTH-1:0];
      end
`else
      acc_c = sum_c[ACC_WIDTH-1:0];
`endif
   end

   // Run-control FSM, operand pipeline and accumulator
   always_ff @(posedge clk) begin
      if (!rst_n || Clr) begin
         state  <= IDLE;
         v1     <= 1'b0;
         sgn_q  <= 1'b0;
         prod_q <= '0;
         len_q  <= '0;
         Bout   <= '0;
         Cout   <= '0;
         Cnt    <= '0;
         Done   <= 1'b0;
         Ovf    <= 1'b0;
      end else begin
         v1 <= accept_c;
         if (accept_c) begin
            prod_q <= prod_c;
            Bout   <= Bin;
         end
         if (start_c) begin
            Cout  <= '0;
            Ovf   <= 1'b0;
            Done  <= 1'b0;
            sgn_q <= Signed;
            len_q <= Len;
            if (Len == '0) begin
               Cnt   <= '0;
               state <= DRAIN;
            end else begin
               Cnt   <= CNT_WIDTH'(En);
               state <= (En && Len == CNT_WIDTH'(1)) ? DRAIN : RUN;
            end
         end else begin
            if (v1) begin
               Cout <= acc_c;
               if (ovf_c) begin
                  Ovf <= 1'b1;
               end
            end
            case (state)
               RUN: begin
                  if (En) begin
                     Cnt <= cnt_inc_c;
                     if (cnt_inc_c == len_q) begin
                        state <= DRAIN;
                     end
                  end
               end
               DRAIN: begin
                  state <= DONE;
                  Done  <= 1'b1;
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: arithmetic run model checked every cycle plus directed literal checks.
// Runs a 24-bit and a 16-bit accumulator instance side by side; honours MAC_SAT_EN if defined.
module tb_mac_seq;

`ifdef MAC_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       Start;
   logic [7:0] Len;
   logic       Signed;
   logic       En;
   logic       Clr;
   logic [7:0] Ain;
   logic [7:0] Bin;

   logic [7:0]  Bout, Bout16;
   logic [23:0] Cout;
   logic [15:0] Cout16;
   logic [7:0]  Cnt, Cnt16;
   logic        Done, Done16, Ovf, Ovf16;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mac_seq #(.DATA_WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .Start(Start), .Len(Len), .Signed(Signed), .En(En),
      .Clr(Clr), .Ain(Ain), .Bin(Bin), .Bout(Bout), .Cout(Cout), .Cnt(Cnt),
      .Done(Done), .Ovf(Ovf));

   mac_seq #(.DATA_WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .Start(Start), .Len(Len), .Signed(Signed), .En(En),
      .Clr(Clr), .Ain(Ain), .Bin(Bin), .Bout(Bout16), .Cout(Cout16), .Cnt(Cnt16),
      .Done(Done16), .Ovf(Ovf16));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: accumulator as a true integer in the mode's range, run phase, beat count
   int     wid [2] = '{24, 16};
   longint m_acc [2];
   bit     m_ovf [2];
   int     m_ph, m_cnt, m_len, m_bout;
   bit     m_sgn, m_pv, started;
   longint m_prod;

   function automatic logic [63:0] exp_cout(input int i);
      longint one;
      one = 1;
      return 64'(m_acc[i] & ((one << wid[i]) - 1));
   endfunction

   always @(posedge clk) begin
      bit st, ok;
      longint one, s, hi, lo;
      one = 1;
      if (!rst_n || Clr) begin
         for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 0;
         end
         m_ph = P_IDLE; m_cnt = 0; m_len = 0; m_bout = 0; m_sgn = 0; m_pv = 0; m_prod = 0;
      end else begin
         st = Start && (m_ph == P_IDLE || m_ph == P_DONE);
         ok = En && (m_ph == P_IDLE || m_ph == P_RUN || (m_ph == P_DONE && Start));
         if (st) begin
            for (int i = 0; i < 2; i++) begin
               m_acc[i] = 0;
               m_ovf[i] = 0;
            end
            m_sgn = Signed;
            m_len = int'(Len);
            if (Len == 0) begin
               m_cnt = 0;
               m_ph  = P_DRAIN;
            end else begin
               m_cnt = ok ? 1 : 0;
               m_ph  = (ok && m_len == 1) ? P_DRAIN : P_RUN;
            end
         end else begin
            if (m_pv) begin
               for (int i = 0; i < 2; i++) begin
                  if (!(SAT && m_ovf[i])) begin
                     if (m_sgn) begin
                        hi = (one << (wid[i] - 1)) - 1;
                        lo = -(one << (wid[i] - 1));
                     end else begin
                        hi = (one << wid[i]) - 1;
                        lo = 0;
                     end
                     s = m_acc[i] + m_prod;
                     if (s > hi) begin
                        m_ovf[i] = 1;
                        m_acc[i] = SAT ? hi : s - (one << wid[i]);
                     end else if (s < lo) begin
                        m_ovf[i] = 1;
                        m_acc[i] = SAT ? lo : s + (one << wid[i]);
                     end else begin
                        m_acc[i] = s;
                     end
                  end
               end
            end
            if (m_ph == P_RUN && ok) begin
               m_cnt++;
               if (m_cnt == m_len) m_ph = P_DRAIN;
            end else if (m_ph == P_DRAIN) begin
               m_ph = P_DONE;
            end
         end
         if (ok) begin
            m_prod = m_sgn ? longint'(int'($signed(Ain)) * int'($signed(Bin)))
                           : longint'(int'(Ain) * int'(Bin));
            m_pv   = 1;
            m_bout = int'(Bin);
         end else begin
            m_pv = 0;
         end
      end
      started = 1;
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (started) begin
         chk("cout24", 64'(Cout), exp_cout(0));
         chk("cout16", 64'(Cout16), exp_cout(1));
         chk("ovf24", 64'(Ovf), 64'(m_ovf[0]));
         chk("ovf16", 64'(Ovf16), 64'(m_ovf[1]));
         chk("bout", 64'(Bout), 64'(m_bout));
         chk("cnt", 64'(Cnt), 64'(m_cnt));
         chk("done", 64'(Done), 64'(m_ph == P_DONE));
      end
   end

   task automatic cyc(input bit st, input int ln, input bit sg, input bit en,
                      input int a, input int b);
      Start = st; Len = 8'(ln); Signed = sg; En = en; Ain = 8'(a); Bin = 8'(b);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n = 1'b0; Clr = 1'b0;
      Start = 0; Len = 0; Signed = 0; En = 0; Ain = 0; Bin = 0;
      idle(2);
      rst_n = 1'b1;
      chk("rst_cout", 64'(Cout), 64'h0);
      chk("rst_done", 64'(Done), 64'h0);
      chk("rst_bout", 64'(Bout), 64'h0);

      // Free-run in IDLE: 3*4 + 5*6
      cyc(0, 0, 0, 1, 3, 4);
      cyc(0, 0, 0, 1, 5, 6);
      idle(1);
      chk("free_cout", 64'(Cout), 64'd42);
      chk("free_cnt", 64'(Cnt), 64'd0);
      chk("free_done", 64'(Done), 64'd0);
      Clr = 1'b1; idle(1); Clr = 1'b0;

      // Unsigned run, Len 4 of 255*255; En kept high through DRAIN/DONE
      cyc(1, 4, 0, 1, 255, 255);
      chk("u_cnt1", 64'(Cnt), 64'd1);
      repeat (3) cyc(0, 0, 0, 1, 255, 255);
      chk("u_nodone", 64'(Done), 64'd0);
      cyc(0, 0, 0, 1, 255, 255);
      chk("u_done", 64'(Done), 64'd1);
      chk("u_cout", 64'(Cout), 64'h03F804);
      chk("u_cnt", 64'(Cnt), 64'd4);
      chk("u_ovf", 64'(Ovf), 64'd0);
      repeat (2) cyc(0, 0, 0, 1, 255, 255);
      chk("u_hold", 64'(Cout), 64'h03F804);

      // Signed run started from DONE with a beat on the Start cycle
      cyc(1, 3, 1, 1, -128, 127);
      chk("s_clr", 64'(Cout), 64'h0);
      chk("s_cnt1", 64'(Cnt), 64'd1);
      chk("s_bout", 64'(Bout), 64'd127);
      chk("s_done0", 64'(Done), 64'd0);
      repeat (2) cyc(0, 0, 0, 1, -128, 127);
      chk("s_nodone", 64'(Done), 64'd0);
      idle(1);
      chk("s_done", 64'(Done), 64'd1);
      chk("s_cout", 64'(Cout), 64'hFF4180);
      chk("s_ovf", 64'(Ovf), 64'd0);

      // Len = 0
      cyc(1, 0, 0, 0, 0, 0);
      chk("z_done0", 64'(Done), 64'd0);
      idle(1);
      chk("z_done", 64'(Done), 64'd1);
      chk("z_cout", 64'(Cout), 64'h0);

      // Overflow of the 16-bit instance
      cyc(1, 2, 0, 1, 255, 255);
      cyc(0, 0, 0, 1, 255, 255);
      idle(1);
      chk("o_done", 64'(Done16), 64'd1);
      chk("o_cout16", 64'(Cout16), SAT ? 64'hFFFF : 64'hFC02);
      chk("o_ovf16", 64'(Ovf16), 64'd1);
      chk("o_cout24", 64'(Cout), 64'h01FC02);

      // Clr after 2 of 4 beats
      cyc(1, 4, 0, 1, 2, 3);
      cyc(0, 0, 0, 1, 2, 3);
      chk("c_cnt2", 64'(Cnt), 64'd2);
      Clr = 1'b1; idle(1); Clr = 1'b0;
      chk("c_cout", 64'(Cout), 64'h0);
      chk("c_cnt", 64'(Cnt), 64'h0);
      chk("c_bout", 64'(Bout), 64'h0);
      chk("c_done", 64'(Done), 64'h0);
      cyc(0, 0, 0, 1, 2, 2);
      idle(1);
      chk("c_idle_cout", 64'(Cout), 64'd4);
      chk("c_idle_cnt", 64'(Cnt), 64'd0);

      // Synchronous reset after 2 of 4 beats
      cyc(1, 4, 0, 1, 2, 3);
      cyc(0, 0, 0, 1, 2, 3);
      rst_n = 1'b0;
      Start = 0; En = 0;
      #2;
      chk("r_sync", 64'(Cnt), 64'd2);
      @(posedge clk);
      #1;
      chk("r_cout", 64'(Cout), 64'h0);
      chk("r_cnt", 64'(Cnt), 64'h0);
      chk("r_bout", 64'(Bout), 64'h0);
      rst_n = 1'b1;
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
